// File: rtl/sfo_search_controller_pkg.sv
// Shared definitions for the SFO hypothesis search: fixed-point widths,
// controller state encoding and the hypothesis stepping helper.
package sfo_search_controller_pkg;

   localparam int SFO_INT_WIDTH       = 8;
   localparam int SFO_FRAC_WIDTH      = 16;
   localparam int SFO_FRAC_RANGE      = 50000;
   localparam int FFT_SHIFT_WIDTH     = 5;
   localparam int CORR_MANTISSA_WIDTH = 26;

   // Fraction range widened by one bit so frac + step can be compared without overflow.
   localparam logic [SFO_FRAC_WIDTH:0]  FRAC_RANGE_EXT = (SFO_FRAC_WIDTH+1)'(SFO_FRAC_RANGE);
   localparam logic [SFO_INT_WIDTH-1:0] INT_ONE        = SFO_INT_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_LOAD,
      ST_STREAM,
      ST_WAIT,
      ST_NEXT,
      ST_DONE
   } sfo_state_t;

   typedef struct packed {
      logic [SFO_INT_WIDTH-1:0]  int_part;
      logic [SFO_FRAC_WIDTH-1:0] frac_part;
   } sfo_hyp_t;

   // Advance a hypothesis by a fractional step; a carry out of the fraction
   // bumps the integer part, which wraps at its natural width.
   function automatic sfo_hyp_t sfo_hyp_step(input sfo_hyp_t cur,
                                             input logic [SFO_FRAC_WIDTH-1:0] step);
      logic [SFO_FRAC_WIDTH:0] frac_sum;
      logic [SFO_FRAC_WIDTH:0] frac_wrapped;
      sfo_hyp_t nxt;
      frac_sum     = {1'b0, cur.frac_part} + {1'b0, step};
      frac_wrapped = frac_sum - FRAC_RANGE_EXT;
      nxt          = cur;
      if (frac_sum >= FRAC_RANGE_EXT) begin
         nxt.frac_part = frac_wrapped[SFO_FRAC_WIDTH-1:0];
         nxt.int_part  = cur.int_part + INT_ONE;
      end else begin
         nxt.frac_part = frac_sum[SFO_FRAC_WIDTH-1:0];
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sfo_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered (1-cycle) read. Contents are deliberately never reset.
module sfo_frame_ram #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rd_data_reg;

   // Write port plus registered read so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/sfo_search_controller.sv
// SFO search controller: captures one FFT magnitude frame, then for each
// sampling-frequency-offset hypothesis resets the correlator, replays the
// frame through it, waits for its score and keeps the best hypothesis.
module sfo_search_controller
   import sfo_search_controller_pkg::*;
#(
   parameter int FFT_LEN_LOG2 = 9,
   parameter int POWER_WIDTH  = 16,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic [SFO_INT_WIDTH-1:0]       sfo_start_int,
   input  logic [SFO_FRAC_WIDTH-1:0]      sfo_start_frac,
   input  logic [SFO_FRAC_WIDTH-1:0]      sfo_step_frac,
   input  logic [7:0]                     num_hypotheses,
   input  logic                           fft_mag_in_valid,
   input  logic [POWER_WIDTH-1:0]         fft_mag_in,
   input  logic [FFT_SHIFT_WIDTH-1:0]     fft_mag_exponent_in,
   output logic [SFO_INT_WIDTH-1:0]       sfo_int_part,
   output logic [SFO_FRAC_WIDTH-1:0]      sfo_frac_part,
   output logic                           correlation_reset,
   output logic                           correlation_update,
   output logic [POWER_WIDTH-1:0]         fft_mag_out,
   output logic [FFT_SHIFT_WIDTH-1:0]     fft_mag_exponent_out,
   input  logic [CORR_MANTISSA_WIDTH:0]   correlation_in,
   input  logic                           correlation_in_valid,
   output logic [SFO_INT_WIDTH-1:0]       best_sfo_int,
   output logic [SFO_FRAC_WIDTH-1:0]      best_sfo_frac,
   output logic [CORR_MANTISSA_WIDTH:0]   best_correlation,
   output logic                           best_valid,
   output logic                           busy,
   output logic                           timeout_err,
   output logic                           overrun_err
);

   localparam logic [FFT_LEN_LOG2-1:0] ADDR_LAST = '1;
   localparam logic [FFT_LEN_LOG2-1:0] ADDR_ONE  = FFT_LEN_LOG2'(1);
   localparam logic [15:0]             WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

   sfo_state_t                   state_reg, state_next;
   logic [FFT_LEN_LOG2-1:0]      wr_addr_reg;
   logic [FFT_LEN_LOG2-1:0]      bin_cnt_reg;
   logic                         load_cnt_reg;
   logic [15:0]                  wait_cnt_reg;
   logic [8:0]                   hyp_cnt_reg;
   sfo_hyp_t                     hyp_reg;
   sfo_hyp_t                     best_hyp_reg;
   logic [CORR_MANTISSA_WIDTH:0] score_reg;
   logic [CORR_MANTISSA_WIDTH:0] best_corr_reg;
   logic [FFT_SHIFT_WIDTH-1:0]   exp_reg;
   logic                         timeout_err_reg;
   logic                         overrun_err_reg;
   logic                         abort_reset_reg;

   logic                         capture_wr;
   logic [FFT_LEN_LOG2-1:0]      rd_addr;
   logic [POWER_WIDTH-1:0]       rd_data;
   logic [8:0]                   num_eff;
   logic [8:0]                   hyp_cnt_inc;
   logic                         stream_active;

   assign capture_wr    = (state_reg == ST_CAPTURE) && fft_mag_in_valid;
   assign num_eff       = (num_hypotheses == 8'd0) ? 9'd1 : {1'b0, num_hypotheses};
   assign hyp_cnt_inc   = hyp_cnt_reg + 9'd1;
   assign stream_active = (state_reg == ST_STREAM);
   // Read one bin ahead: the last LOAD cycle fetches bin 0, STREAM cycle k fetches k+1.
   assign rd_addr       = stream_active ? (bin_cnt_reg + ADDR_ONE) : '0;

   sfo_frame_ram #(
      .ADDR_WIDTH (FFT_LEN_LOG2),
      .DATA_WIDTH (POWER_WIDTH)
   ) u_frame_ram (
      .clk     (clk),
      .wr_en   (capture_wr),
      .wr_addr (wr_addr_reg),
      .wr_data (fft_mag_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // State register; reset dominates abort and start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_next         = state_reg;
      busy               = (state_reg != ST_IDLE);
      correlation_update = stream_active;
      correlation_reset  = (state_reg == ST_LOAD) || abort_reset_reg;
      best_valid         = (state_reg == ST_DONE);
      fft_mag_out        = stream_active ? rd_data : '0;
      case (state_reg)
         ST_IDLE:    if (start) state_next = ST_CAPTURE;
         ST_CAPTURE: if (fft_mag_in_valid && (wr_addr_reg == ADDR_LAST)) state_next = ST_LOAD;
         ST_LOAD:    if (load_cnt_reg) state_next = ST_STREAM;
         ST_STREAM:  if (bin_cnt_reg == ADDR_LAST) state_next = ST_WAIT;
         ST_WAIT:    if (correlation_in_valid || (wait_cnt_reg == WAIT_LAST)) state_next = ST_NEXT;
         ST_NEXT:    state_next = (hyp_cnt_inc < num_eff) ? ST_LOAD : ST_DONE;
         ST_DONE:    state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
      if (abort) begin
         state_next = ST_IDLE;
      end
   end

   // Counters, hypothesis, scoring and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr_reg     <= '0;
         bin_cnt_reg     <= '0;
         load_cnt_reg    <= 1'b0;
         wait_cnt_reg    <= '0;
         hyp_cnt_reg     <= '0;
         hyp_reg         <= '0;
         best_hyp_reg    <= '0;
         score_reg       <= '0;
         best_corr_reg   <= '0;
         exp_reg         <= '0;
         timeout_err_reg <= 1'b0;
         overrun_err_reg <= 1'b0;
         abort_reset_reg <= 1'b0;
      end else begin
         timeout_err_reg <= 1'b0;
         overrun_err_reg <= fft_mag_in_valid && (state_reg != ST_IDLE) && (state_reg != ST_CAPTURE);
         abort_reset_reg <= abort;
         if (!abort) begin
            case (state_reg)
               ST_IDLE: begin
                  wr_addr_reg <= '0;
                  hyp_cnt_reg <= '0;
               end
               ST_CAPTURE: begin
                  if (fft_mag_in_valid) begin
                     wr_addr_reg <= wr_addr_reg + ADDR_ONE;
                     if (wr_addr_reg == '0) begin
                        exp_reg <= fft_mag_exponent_in;
                     end
                     if (wr_addr_reg == ADDR_LAST) begin
                        hyp_reg      <= {sfo_start_int, sfo_start_frac};
                        load_cnt_reg <= 1'b0;
                     end
                  end
               end
               ST_LOAD: begin
                  load_cnt_reg <= ~load_cnt_reg;
                  bin_cnt_reg  <= '0;
               end
               ST_STREAM: begin
                  bin_cnt_reg  <= bin_cnt_reg + ADDR_ONE;
                  wait_cnt_reg <= '0;
               end
               ST_WAIT: begin
                  wait_cnt_reg <= wait_cnt_reg + 16'd1;
                  if (correlation_in_valid) begin
                     score_reg <= correlation_in;
                  end else if (wait_cnt_reg == WAIT_LAST) begin
                     score_reg       <= '0;
                     timeout_err_reg <= 1'b1;
                  end
               end
               ST_NEXT: begin
                  // Strict compare keeps the earlier hypothesis on a tie.
                  if ((hyp_cnt_reg == 9'd0) || (score_reg > best_corr_reg)) begin
                     best_hyp_reg  <= hyp_reg;
                     best_corr_reg <= score_reg;
                  end
                  hyp_reg      <= sfo_hyp_step(hyp_reg, sfo_step_frac);
                  hyp_cnt_reg  <= hyp_cnt_inc;
                  load_cnt_reg <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign sfo_int_part         = hyp_reg.int_part;
   assign sfo_frac_part        = hyp_reg.frac_part;
   assign fft_mag_exponent_out = exp_reg;
   assign best_sfo_int         = best_hyp_reg.int_part;
   assign best_sfo_frac        = best_hyp_reg.frac_part;
   assign best_correlation     = best_corr_reg;
   assign timeout_err          = timeout_err_reg;
   assign overrun_err          = overrun_err_reg;

endmodule
